fft_job_scheduler: RTL and testbench
====================================

# fft_job_scheduler

Frame-level scheduler that shares one 8-point floating-point FFT core between two sample requesters. It arbitrates round-robin on frame boundaries and streams the granted requester's 8 complex samples into the core. It then collects the core's 8 results, tags each with requester id and bin index, and guards the core with a drain watchdog. It sits between the board/host front end and the FFT core, replacing the fixed load FSM.

## Interface
- DW, 32, IEEE-754 single word width of each real/imag component
- TIMEOUT, 255, max idle cycles allowed in DRAIN between core results before abort
- i_clk  in  1  clock
- i_rst_n  in  1  reset, asynchronous, active-low
- i_req_valid  in  2  per-requester sample valid (bit r = requester r)
- i_req_re  in  2*DW  packed real samples, requester r at [r*DW +: DW]
- i_req_im  in  2*DW  packed imag samples, same packing
- o_req_ready  out  2  per-requester sample accept; a beat transfers when valid&ready
- o_core_start  out  1  one-cycle start pulse to core
- o_core_valid  out  1  sample valid to core
- o_core_re / o_core_im  out  DW each  sample to core
- i_core_valid  in  1  core result valid
- i_core_re / i_core_im  in  DW each  core result
- i_core_done  in  1  core frame-complete flag
- o_res_valid  out  1  tagged result valid, no backpressure
- o_res_re / o_res_im  out  DW each  result data
- o_res_id  out  1  requester that owns the result
- o_res_idx  out  3  bin index 0..7, natural order
- o_res_last  out  1  high with idx 7
- o_busy  out  1  high in any state except IDLE
- o_err_timeout  out  1  sticky watchdog abort flag
- o_frames_done  out  16  completed-frame counter, wraps

## Operation
- States: IDLE, START, LOAD, DRAIN.
- IDLE: if any i_req_valid is high, latch grant, go to START. Both high → grant the requester not granted last. The last-grant pointer resets so requester 0 wins the first tie. A single requester may be granted repeatedly.
- START: o_core_start=1 for exactly one cycle; clear o_err_timeout, the load count and the result count; go to LOAD.
- LOAD: o_req_ready[grant]=1 while load count<8, other ready bit 0. o_core_valid = i_req_valid[grant]; o_core_re/im = the granted requester's bus, combinational pass-through. Each handshake increments the load count. Requester bubbles are allowed and produce no core beat. After the 8th handshake go to DRAIN.
- DRAIN: each i_core_valid registers a result: o_res_* = data, o_res_id=grant, o_res_idx=result count. The result count increments and o_res_last = (idx==7). A done-seen flag latches i_core_done. The frame completes when 8 results have been seen and done-seen is set, including done arriving in the same cycle as the 8th result or later. On completion, o_frames_done+1 and go to IDLE.
- Watchdog: in DRAIN, a counter increments on each cycle with no i_core_valid and resets on i_core_valid. When it reaches TIMEOUT, set o_err_timeout and return to IDLE without incrementing o_frames_done. Results already forwarded stand.
- i_core_valid/i_core_done outside DRAIN are ignored. Results beyond 8 in DRAIN are ignored.
- Grant pointer updates on entering START.

## Timing
- Reset values: o_req_ready=0, o_core_start=0, o_core_valid=0, o_core_re/im=0, o_res_valid=0, o_res_re/im=0, o_res_id=0, o_res_idx=0, o_res_last=0, o_busy=0, o_err_timeout=0, o_frames_done=0; state IDLE; pointer favours requester 0.
- Asynchronous reset mid-frame returns to IDLE immediately. The core is not otherwise notified and shares the same reset.
- Request seen in IDLE at cycle N: o_core_start at N+1; first possible sample beat at N+2. Minimum LOAD = 8 cycles.
- o_res_* is registered: 1-cycle latency from i_core_valid; o_res_valid is a single-cycle pulse per result.
- o_core_re/im are driven 0 when o_core_valid=0.
- Back-to-back frames: after DRAIN→IDLE, there is at least 1 IDLE cycle before the next START.

## Test plan
- Single frame, req0, 8 consecutive beats with data 0x4036A800/0xC01E1800 etc. → start pulse, 8 core beats, 8 o_res with id=0, idx 0..7, last at idx 7, o_frames_done=1.
- Both requesters valid continuously for 4 frames → grant order 0,1,0,1; o_req_ready never high for both; o_res_id matches.
- Req1 with bubbles (valid every other cycle) → LOAD spans 15 cycles, exactly 8 core beats, data order preserved.
- i_core_done arrives 5 cycles after the 8th result → stay in DRAIN, then complete; done coincident with the 8th result → complete in that cycle.
- Core stalls after 3 results with TIMEOUT=16 → o_err_timeout=1 after 16 idle cycles, return to IDLE, o_frames_done unchanged; next START clears the flag.
- Assert i_rst_n low mid-LOAD at beat 4 → all outputs at reset values, IDLE; next frame begins cleanly with idx 0.

Source files
------------

// File: rtl/fft_job_scheduler_if.sv
// Signal bundle between the requesters, the shared FFT core and the tagged-result sink.
interface fft_job_scheduler_if #(
  parameter int DW = 32
);
  logic [1:0]      i_req_valid;
  logic [2*DW-1:0] i_req_re;
  logic [2*DW-1:0] i_req_im;
  logic [1:0]      o_req_ready;
  logic            o_core_start;
  logic            o_core_valid;
  logic [DW-1:0]   o_core_re;
  logic [DW-1:0]   o_core_im;
  logic            i_core_valid;
  logic [DW-1:0]   i_core_re;
  logic [DW-1:0]   i_core_im;
  logic            i_core_done;
  logic            o_res_valid;
  logic [DW-1:0]   o_res_re;
  logic [DW-1:0]   o_res_im;
  logic            o_res_id;
  logic [2:0]      o_res_idx;
  logic            o_res_last;
  logic            o_busy;
  logic            o_err_timeout;
  logic [15:0]     o_frames_done;

  modport slave (
    input  i_req_valid, i_req_re, i_req_im,
    input  i_core_valid, i_core_re, i_core_im, i_core_done,
    output o_req_ready, o_core_start, o_core_valid, o_core_re, o_core_im,
    output o_res_valid, o_res_re, o_res_im, o_res_id, o_res_idx, o_res_last,
    output o_busy, o_err_timeout, o_frames_done
  );

  modport master (
    output i_req_valid, i_req_re, i_req_im,
    output i_core_valid, i_core_re, i_core_im, i_core_done,
    input  o_req_ready, o_core_start, o_core_valid, o_core_re, o_core_im,
    input  o_res_valid, o_res_re, o_res_im, o_res_id, o_res_idx, o_res_last,
    input  o_busy, o_err_timeout, o_frames_done
  );
endinterface

// File: rtl/fft_job_scheduler.sv
// Shares one 8-point FFT core between two requesters: round-robin frame grant,
// sample load, tagged result collection and a drain watchdog.
module fft_job_scheduler #(
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  fft_job_scheduler_if.slave bus
);

  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, START, LOAD, DRAIN} state_t;

  state_t          state, state_nxt;
  logic            grant, last_grant;
  logic [3:0]      load_cnt, res_cnt, res_cnt_nxt;
  logic            done_seen;
  logic [WD_W-1:0] wd_cnt;
  logic            err_timeout;
  logic [15:0]     frames_done;

  logic            res_valid_p1;
  logic [DW-1:0]   res_re_p1, res_im_p1;
  logic            res_id_p1;
  logic [2:0]      res_idx_p1;
  logic            res_last_p1;

  logic            req_any, grant_pick, load_hs, res_take, frame_done, wd_expire;
  logic [1:0]      req_ready;
  logic            core_start, core_valid, busy;
  logic [DW-1:0]   sel_re, sel_im, core_re, core_im;

  assign req_any     = |bus.i_req_valid;
  // On a tie the requester not served last wins; otherwise whoever is asking.
  assign grant_pick  = (&bus.i_req_valid) ? ~last_grant : bus.i_req_valid[1];
  assign sel_re      = grant ? bus.i_req_re[2*DW-1:DW] : bus.i_req_re[DW-1:0];
  assign sel_im      = grant ? bus.i_req_im[2*DW-1:DW] : bus.i_req_im[DW-1:0];
  assign load_hs     = (state == LOAD) && bus.i_req_valid[grant] && (load_cnt < 4'd8);
  assign res_take    = (state == DRAIN) && bus.i_core_valid && (res_cnt < 4'd8);
  assign res_cnt_nxt = res_cnt + {3'd0, res_take};
  // Done may precede, coincide with or follow the 8th result.
  assign frame_done  = (state == DRAIN) && (res_cnt_nxt == 4'd8) &&
                       (done_seen || bus.i_core_done);
  assign wd_expire   = (state == DRAIN) && !bus.i_core_valid && (wd_cnt == WD_LIMIT);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_any) state_nxt = START;
      START:   state_nxt = LOAD;
      LOAD:    if (load_hs && (load_cnt == 4'd7)) state_nxt = DRAIN;
      DRAIN:   if (frame_done || wd_expire) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = 2'b00;
    core_start = 1'b0;
    core_valid = 1'b0;
    core_re    = '0;
    core_im    = '0;
    busy       = (state != IDLE);
    case (state)
      START: core_start = 1'b1;
      LOAD: begin
        req_ready[grant] = (load_cnt < 4'd8);
        core_valid       = load_hs;
        if (load_hs) begin
          core_re = sel_re;
          core_im = sel_im;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      grant       <= 1'b0;
      last_grant  <= 1'b1;
      load_cnt    <= '0;
      res_cnt     <= '0;
      done_seen   <= 1'b0;
      wd_cnt      <= '0;
      err_timeout <= 1'b0;
      frames_done <= '0;
    end else begin
      case (state)
        IDLE: if (req_any) begin
          grant      <= grant_pick;
          last_grant <= grant_pick;
        end
        START: begin
          err_timeout <= 1'b0;
          load_cnt    <= '0;
          res_cnt     <= '0;
          done_seen   <= 1'b0;
          wd_cnt      <= '0;
        end
        LOAD: if (load_hs) load_cnt <= load_cnt + 4'd1;
        DRAIN: begin
          res_cnt <= res_cnt_nxt;
          if (bus.i_core_done) done_seen <= 1'b1;
          wd_cnt <= bus.i_core_valid ? '0 : wd_cnt + WD_W'(1);
          if (frame_done)     frames_done <= frames_done + 16'd1;
          else if (wd_expire) err_timeout <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Result stage: one register between core result and tagged output.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      res_valid_p1 <= 1'b0;
      res_re_p1    <= '0;
      res_im_p1    <= '0;
      res_id_p1    <= 1'b0;
      res_idx_p1   <= '0;
      res_last_p1  <= 1'b0;
    end else begin
      res_valid_p1 <= res_take;
      if (res_take) begin
        res_re_p1   <= bus.i_core_re;
        res_im_p1   <= bus.i_core_im;
        res_id_p1   <= grant;
        res_idx_p1  <= res_cnt[2:0];
        res_last_p1 <= (res_cnt == 4'd7);
      end
    end
  end

  assign bus.o_req_ready   = req_ready;
  assign bus.o_core_start  = core_start;
  assign bus.o_core_valid  = core_valid;
  assign bus.o_core_re     = core_re;
  assign bus.o_core_im     = core_im;
  assign bus.o_res_valid   = res_valid_p1;
  assign bus.o_res_re      = res_re_p1;
  assign bus.o_res_im      = res_im_p1;
  assign bus.o_res_id      = res_id_p1;
  assign bus.o_res_idx     = res_idx_p1;
  assign bus.o_res_last    = res_last_p1;
  assign bus.o_busy        = busy;
  assign bus.o_err_timeout = err_timeout;
  assign bus.o_frames_done = frames_done;

endmodule

// File: tb/tb_fft_job_scheduler.sv
// Directed bench for fft_job_scheduler: frame table plus timeout and reset sequences.
module tb_fft_job_scheduler;
  localparam int DW  = 32;
  localparam int TMO = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fft_job_scheduler_if #(.DW(DW)) bus ();
  fft_job_scheduler #(.DW(DW), .TIMEOUT(TMO)) dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bus));

  typedef struct {
    logic [1:0] mask;
    bit         bubble;
    int         gap;
    int         dd;
    logic [1:0] end_mask;
    bit         exp_id;
    int         exp_frames;
    int         exp_lc;
  } frame_t;

  int         total = 0;
  int         bad = 0;
  int         sidx [2];
  logic [1:0] last_v = 2'b00;
  frame_t     tbl [9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] smp_re(input int r, input int n);
    logic [31:0] b;
    b = 32'h4036A800;
    return b + 32'(r << 20) + 32'(n);
  endfunction

  function automatic logic [31:0] smp_im(input int r, input int n);
    logic [31:0] b;
    b = 32'hC01E1800;
    return b + 32'(r << 20) + 32'(n);
  endfunction

  function automatic logic [31:0] rres_re(input int fr, input int j);
    logic [31:0] b;
    b = 32'h3F800000;
    return b + 32'(fr << 8) + 32'(j);
  endfunction

  function automatic logic [31:0] rres_im(input int fr, input int j);
    logic [31:0] b;
    b = 32'hBF800000;
    return b + 32'(fr << 8) + 32'(j);
  endfunction

  // One clock: drive at the falling edge, settle, then let requesters advance on handshake.
  task automatic cyc(input logic [1:0] v, input logic cv, input logic [31:0] cre,
                     input logic [31:0] cim, input logic cd);
    @(negedge clk);
    bus.i_req_valid  = v;
    bus.i_req_re     = {smp_re(1, sidx[1]), smp_re(0, sidx[0])};
    bus.i_req_im     = {smp_im(1, sidx[1]), smp_im(0, sidx[0])};
    bus.i_core_valid = cv;
    bus.i_core_re    = cre;
    bus.i_core_im    = cim;
    bus.i_core_done  = cd;
    last_v           = v;
    #1;
    for (int r = 0; r < 2; r++)
      if (v[r] && bus.o_req_ready[r]) sidx[r]++;
  endtask

  task automatic check_reset_outputs();
    chk("rst_ready", bus.o_req_ready, 0);
    chk("rst_start", bus.o_core_start, 0);
    chk("rst_core_valid", bus.o_core_valid, 0);
    chk("rst_core_re", bus.o_core_re, 0);
    chk("rst_core_im", bus.o_core_im, 0);
    chk("rst_res_valid", bus.o_res_valid, 0);
    chk("rst_res_re", bus.o_res_re, 0);
    chk("rst_res_im", bus.o_res_im, 0);
    chk("rst_res_id", bus.o_res_id, 0);
    chk("rst_res_idx", bus.o_res_idx, 0);
    chk("rst_res_last", bus.o_res_last, 0);
    chk("rst_busy", bus.o_busy, 0);
    chk("rst_err", bus.o_err_timeout, 0);
    chk("rst_frames", bus.o_frames_done, 0);
  endtask

  task automatic start_phase(input logic [1:0] mask);
    int  n;
    int  exp_lat;
    bit  seen;
    n = 0;
    seen = 1'b0;
    exp_lat = (last_v != 2'b00) ? 1 : 2;
    while (!seen && n < 6) begin
      cyc(mask, 1'b0, 32'h0, 32'h0, 1'b0);
      n++;
      if (bus.o_core_start) seen = 1'b1;
    end
    chk("start_seen", seen, 1);
    chk("start_latency", n, exp_lat);
    chk("start_no_ready", bus.o_req_ready, 0);
    chk("start_no_core_valid", bus.o_core_valid, 0);
    chk("start_busy", bus.o_busy, 1);
  endtask

  task automatic load_phase(input logic [1:0] mask, input bit bubble, input bit exp_id,
                            output int cycles);
    int         base, nb, lc;
    logic [1:0] v;
    base = sidx[exp_id];
    nb = 0;
    lc = 0;
    while (nb < 8 && lc < 40) begin
      v = (bubble && (lc % 2 == 1)) ? 2'b00 : mask;
      // Core valid/done noise during LOAD must be ignored.
      cyc(v, 1'b1, 32'hDEAD0000, 32'hBEEF0000, 1'b1);
      chk("load_start_low", bus.o_core_start, 0);
      chk("load_ready", bus.o_req_ready, exp_id ? 2'b10 : 2'b01);
      chk("load_core_valid", bus.o_core_valid, v[exp_id]);
      chk("load_res_quiet", bus.o_res_valid, 0);
      chk("load_err_clear", bus.o_err_timeout, 0);
      if (bus.o_core_valid) begin
        chk("load_core_re", bus.o_core_re, smp_re(exp_id, base + nb));
        chk("load_core_im", bus.o_core_im, smp_im(exp_id, base + nb));
        nb++;
      end else begin
        chk("load_core_re_zero", bus.o_core_re, 0);
        chk("load_core_im_zero", bus.o_core_im, 0);
      end
      lc++;
    end
    chk("load_beats", nb, 8);
    cycles = lc;
  endtask

  task automatic check_prev(input bit pv, input int pj, input bit exp_id, input int fr);
    chk("res_valid", bus.o_res_valid, pv);
    if (pv) begin
      chk("res_re", bus.o_res_re, rres_re(fr, pj));
      chk("res_im", bus.o_res_im, rres_im(fr, pj));
      chk("res_id", bus.o_res_id, exp_id);
      chk("res_idx", bus.o_res_idx, pj);
      chk("res_last", bus.o_res_last, (pj == 7));
    end
  endtask

  task automatic drain_phase(input logic [1:0] mask, input logic [1:0] end_mask, input int gap,
                             input int dd, input bit exp_id, input int fr, input int exp_frames);
    int   lres, lastc, j, pj;
    bit   cv, extra, pv;
    lres = 7 * (gap + 1);
    lastc = lres + dd;
    pv = 1'b0;
    pj = 0;
    for (int c = 0; c <= lastc; c++) begin
      cv = (c % (gap + 1) == 0) && (c <= lres);
      j = c / (gap + 1);
      extra = (dd >= 2) && (c == lres + 1);
      cyc(mask, cv | extra, cv ? rres_re(fr, j) : 32'h7FC00000,
          cv ? rres_im(fr, j) : 32'h7FC00000, (c == lastc));
      check_prev(pv, pj, exp_id, fr);
      chk("drain_busy", bus.o_busy, 1);
      chk("drain_ready", bus.o_req_ready, 0);
      chk("drain_core_valid", bus.o_core_valid, 0);
      pv = cv;
      pj = j;
    end
    cyc(end_mask, 1'b0, 32'h0, 32'h0, 1'b0);
    check_prev(pv, pj, exp_id, fr);
    chk("end_idle", bus.o_busy, 0);
    chk("end_frames", bus.o_frames_done, exp_frames);
    chk("end_err", bus.o_err_timeout, 0);
  endtask

  task automatic run_frame(input frame_t f, input int fr);
    int lc;
    start_phase(f.mask);
    load_phase(f.mask, f.bubble, f.exp_id, lc);
    chk("load_cycles", lc, f.exp_lc);
    drain_phase(f.mask, f.end_mask, f.gap, f.dd, f.exp_id, fr, f.exp_frames);
  endtask

  initial begin
    #200000;
    $display("FAIL global_time_limit: got expired expected completion");
    $fatal(1, "time limit");
  end

  initial begin
    frame_t f;
    int     lc;
    bit     pv;
    int     frames_before;

    sidx[0] = 0;
    sidx[1] = 0;
    bus.i_req_valid  = 2'b00;
    bus.i_req_re     = '0;
    bus.i_req_im     = '0;
    bus.i_core_valid = 1'b0;
    bus.i_core_re    = '0;
    bus.i_core_im    = '0;
    bus.i_core_done  = 1'b0;

    //            mask   bub gap dd end    id frames lc
    tbl[0] = '{2'b11, 1'b0, 0, 0, 2'b11, 1'b0, 1, 8};
    tbl[1] = '{2'b11, 1'b0, 0, 0, 2'b11, 1'b1, 2, 8};
    tbl[2] = '{2'b11, 1'b0, 0, 0, 2'b11, 1'b0, 3, 8};
    tbl[3] = '{2'b11, 1'b0, 0, 0, 2'b00, 1'b1, 4, 8};
    tbl[4] = '{2'b01, 1'b0, 0, 0, 2'b00, 1'b0, 5, 8};
    tbl[5] = '{2'b10, 1'b1, 0, 0, 2'b00, 1'b1, 6, 15};
    tbl[6] = '{2'b10, 1'b0, 0, 5, 2'b00, 1'b1, 7, 8};
    tbl[7] = '{2'b01, 1'b0, 2, 0, 2'b00, 1'b0, 8, 8};
    tbl[8] = '{2'b11, 1'b0, 0, 0, 2'b00, 1'b1, 9, 8};

    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs();
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) run_frame(tbl[i], i);

    // Core stalls after 3 results: watchdog aborts after TMO idle cycles.
    frames_before = 9;
    start_phase(2'b01);
    load_phase(2'b01, 1'b0, 1'b0, lc);
    pv = 1'b0;
    for (int c = 0; c <= 18; c++) begin
      cyc(2'b00, (c < 3), rres_re(20, c), rres_im(20, c), 1'b0);
      check_prev(pv, c - 1, 1'b0, 20);
      chk("wd_busy", bus.o_busy, 1);
      chk("wd_err_low", bus.o_err_timeout, 0);
      pv = (c < 3);
    end
    cyc(2'b00, 1'b0, 32'h0, 32'h0, 1'b0);
    chk("wd_idle", bus.o_busy, 0);
    chk("wd_err_set", bus.o_err_timeout, 1);
    chk("wd_frames_kept", bus.o_frames_done, frames_before);
    cyc(2'b00, 1'b1, 32'h1, 32'h1, 1'b1);
    chk("wd_err_sticky", bus.o_err_timeout, 1);
    chk("wd_ignore_core_idle", bus.o_res_valid, 0);
    f = '{2'b01, 1'b0, 0, 0, 2'b00, 1'b0, 10, 8};
    run_frame(f, 21);

    // Asynchronous reset in the middle of LOAD, after four beats.
    start_phase(2'b01);
    for (int k = 0; k < 4; k++) begin
      cyc(2'b01, 1'b0, 32'h0, 32'h0, 1'b0);
      chk("pre_rst_beat", bus.o_core_valid, 1);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    cyc(2'b00, 1'b0, 32'h0, 32'h0, 1'b0);
    rst_n = 1'b1;
    f = '{2'b11, 1'b0, 0, 0, 2'b00, 1'b0, 1, 8};
    run_frame(f, 22);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
